delay_ff_reset: RTL and testbench

//   Parameterised fixed-latency delay line built from a chain of resettable flip-flops.

---
 rtl/delay_ff_reset.sv | 41 ++++
 tb/tb_delay_ff_reset.sv | 97 +++++++++
 2 files changed

// File: rtl/delay_ff_reset.sv
// Fixed-latency delay line: WIDTH-bit bus carried through DELAY resettable register stages.
// Latency: exactly DELAY core cycles, registered output with no combinational path from in.
// Backpressure: none; the chain advances every cycle and reset discards everything in flight.
module delay_ff_reset #(
    parameter int DELAY = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    if (DELAY < 1 || WIDTH < 1) begin : g_bad_param
        $fatal(1, "delay_ff_reset: DELAY and WIDTH must both be at least 1");
    end

    logic [WIDTH-1:0] stage [DELAY];

    // Reset pin is active-low despite its name; every stage clears so nothing stale leaks out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage[0] <= '0;
        end else begin
            stage[0] <= in;
        end
    end

    for (genvar k = 1; k < DELAY; k++) begin : g_stage
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                stage[k] <= '0;
            end else begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign out = stage[DELAY-1];

endmodule

// File: tb/tb_delay_ff_reset.sv
// Directed bench for delay_ff_reset across several DELAY/WIDTH instances sharing one clock and reset.
module tb_delay_ff_reset;

    logic clk = 1'b0;
    logic rst;

    logic [7:0]  in_a;  logic [7:0]  out_a;   // DELAY=3 WIDTH=8
    logic        in_b;  logic        out_b;   // DELAY=3 WIDTH=1
    logic [4:0]  in_c;  logic [4:0]  out_c;   // DELAY=2 WIDTH=5
    logic [1:0]  in_d;  logic [1:0]  out_d;   // DELAY=4 WIDTH=2
    logic        in_e;  logic        out_e;   // DELAY=1 WIDTH=1
    logic [31:0] in_f;  logic [31:0] out_f;   // DELAY=2 WIDTH=32

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    delay_ff_reset #(.DELAY(3), .WIDTH(8))  u_a (.clk(clk), .reset(rst), .in(in_a), .out(out_a));
    delay_ff_reset #(.DELAY(3), .WIDTH(1))  u_b (.clk(clk), .reset(rst), .in(in_b), .out(out_b));
    delay_ff_reset #(.DELAY(2), .WIDTH(5))  u_c (.clk(clk), .reset(rst), .in(in_c), .out(out_c));
    delay_ff_reset #(.DELAY(4), .WIDTH(2))  u_d (.clk(clk), .reset(rst), .in(in_d), .out(out_d));
    delay_ff_reset #(.DELAY(1), .WIDTH(1))  u_e (.clk(clk), .reset(rst), .in(in_e), .out(out_e));
    delay_ff_reset #(.DELAY(2), .WIDTH(32)) u_f (.clk(clk), .reset(rst), .in(in_f), .out(out_f));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b0;
        in_a = 8'hA5;
        in_b = 1'b1;
        in_c = '0;
        in_d = 2'b11;
        in_e = 1'b0;
        in_f = '0;

        // Reset held for five edges: outputs stay cleared despite live inputs.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_a", 32'(out_a), 32'h0);
            chk("hold_b", 32'(out_b), 32'h0);
            chk("hold_d", 32'(out_d), 32'h0);
        end

        // Release between edges; edge index e counts rising edges after release.
        rst = 1'b1;
        for (int e = 0; e < 20; e++) begin
            in_c = 5'(e);
            in_e = 1'(e & 1);
            in_f = (e == 3) ? 32'hDEADBEEF : 32'h0;
            tick();
            chk("primed_b", 32'(out_b), (e >= 2) ? 32'h1 : 32'h0);
            chk("ramp_c",   32'(out_c), (e >= 1) ? 32'(e - 1) : 32'h0);
            chk("stream_d", 32'(out_d), (e >= 3) ? 32'h3 : 32'h0);
            chk("toggle_e", 32'(out_e), 32'(e & 1));
            chk("wide_f",   out_f,      (e == 4) ? 32'hDEADBEEF : 32'h0);
            chk("data_a",   32'(out_a), (e >= 2) ? 32'hA5 : 32'h0);
        end

        // Asynchronous reset mid-stream: outputs must clear before any further edge.
        #1;
        rst = 1'b0;
        #1;
        chk("async_d", 32'(out_d), 32'h0);
        chk("async_b", 32'(out_b), 32'h0);
        chk("async_a", 32'(out_a), 32'h0);
        tick();
        chk("async_hold_d", 32'(out_d), 32'h0);
        rst = 1'b1;
        for (int e = 0; e < 6; e++) begin
            tick();
            chk("rearm_d", 32'(out_d), (e >= 3) ? 32'h3 : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
